// File: rtl/activation_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : activation_skewer
//  Purpose  : Feeds the left edge of a systolic array. Each accepted beat
//             carries one signed activation per row; row r is delayed by r+1
//             register stages so rows enter the array diagonally. Cycles
//             with no accepted beat inject a zero/invalid bubble on row 0,
//             which ripples down the skew like data. After the last beat of
//             a tile the FSM blocks new input until that beat's final
//             element has left row ROWS-1, then pulses done_o for one cycle.
//
//  Ports    : clk_i       - clock, all state changes on the rising edge
//             rst_ni      - asynchronous active-low reset
//             in_valid_i  - upstream beat valid
//             in_ready_o  - block accepts a beat this cycle
//             in_data_i   - ROWS x DATA_W activations, row r at [r*DATA_W +: DATA_W]
//             in_last_i   - final beat of the tile (qualified by in_valid_i)
//             a_out_o     - skewed activations to array row left-edge inputs
//             a_vld_o     - per-row valid flag travelling with a_out_o
//             done_o      - one-cycle pulse as the tile's last element hits row ROWS-1
//             beat_cnt_o  - (SKEW_BEAT_CNT_EN only) beats accepted in the current tile
//
//  Options  : define SKEW_BEAT_CNT_EN to add the saturating 16-bit beat counter.
//
//  Revision : 1.0 - initial release
// ============================================================================
module activation_skewer #(
   parameter int ROWS   = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [ROWS*DATA_W-1:0] in_data_i,
   input  logic                   in_last_i,
   output logic [ROWS*DATA_W-1:0] a_out_o,
   output logic [ROWS-1:0]        a_vld_o,
   output logic                   done_o
`ifdef SKEW_BEAT_CNT_EN
   ,
   output logic [15:0]            beat_cnt_o
`endif
);

   // Drain counter runs 0 .. ROWS-2; keep at least one bit for tiny arrays.
   localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
   localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic             accept;

   // Ready is masked by reset so nothing upstream sees a ready while held.
   assign in_ready_o = rst_ni & ((state_q == IDLE) | (state_q == STREAM));
   assign accept     = in_valid_i & in_ready_o;
   assign done_o     = (state_q == DONE);

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         IDLE, STREAM: begin
            if (accept) begin
               if (in_last_i) begin
                  // A single-row array has no skew left to drain.
                  state_d     = (ROWS == 1) ? DONE : DRAIN;
                  drain_cnt_d = '0;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_q == c_DRAIN_LAST) begin
               state_d = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Skew chains: row r holds r+1 stages; data and valid move in lockstep.
   // Non-accepted cycles load a zero with valid low (the bubble).
   // ------------------------------------------------------------------------
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] dat_q [r+1];
      logic [r:0]        vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i <= r; i++) begin
               dat_q[i] <= '0;
            end
            vld_q <= '0;
         end else begin
            dat_q[0] <= accept ? in_data_i[r*DATA_W +: DATA_W] : '0;
            vld_q[0] <= accept;
            for (int i = 1; i <= r; i++) begin
               dat_q[i] <= dat_q[i-1];
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      assign a_out_o[r*DATA_W +: DATA_W] = dat_q[r];
      assign a_vld_o[r]                  = vld_q[r];
   end

`ifdef SKEW_BEAT_CNT_EN
   // ------------------------------------------------------------------------
   // Beat counter: cleared on the edge leaving DONE, saturating otherwise.
   // No beat can be accepted in DONE, so the clear never loses a count.
   // ------------------------------------------------------------------------
   logic [15:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (state_q == DONE) begin
         beat_cnt_d = '0;
      end else if (accept && (beat_cnt_q != 16'hFFFF)) begin
         beat_cnt_d = beat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign beat_cnt_o = beat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_activation_skewer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_activation_skewer
//  Purpose  : Self-checking bench for activation_skewer (ROWS=4, DATA_W=8).
//             The driver pushes every expected row element (with the cycle it
//             must appear in) and every expected done pulse into queues; a
//             negedge monitor pops and compares whenever the DUT shows a
//             valid row element or a done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_activation_skewer;

   localparam int ROWS   = 4;
   localparam int DATA_W = 8;
   localparam int W      = ROWS * DATA_W;

   logic          clk_i      = 1'b0;
   logic          rst_ni     = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_last_i  = 1'b0;
   logic [W-1:0]  in_data_i  = '0;
   logic          in_ready_o;
   logic [W-1:0]  a_out_o;
   logic [ROWS-1:0] a_vld_o;
   logic          done_o;
`ifdef SKEW_BEAT_CNT_EN
   logic [15:0]   beat_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   activation_skewer #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .in_last_i  (in_last_i),
      .a_out_o    (a_out_o),
      .a_vld_o    (a_vld_o),
      .done_o     (done_o)
`ifdef SKEW_BEAT_CNT_EN
      ,
      .beat_cnt_o (beat_cnt_o)
`endif
   );

   typedef struct {
      int                row;
      logic [DATA_W-1:0] d;
      int                due;
   } ent_t;

   ent_t rq[$];        // expected row elements, in push order
   int   done_q[$];    // cycles in which done must pulse

   int   cyc        = 0;
   int   busy_until = -1;
   int   checks     = 0;
   int   errors     = 0;
   int   m_bcnt     = 0;
   logic exp_ready  = 1'b0;
   logic in_rst     = 1'b1;

   always @(posedge clk_i) cyc++;

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   task automatic row_check(input int r);
      int                idx;
      logic [DATA_W-1:0] got;
      idx = -1;
      got = a_out_o[r*DATA_W +: DATA_W];
      for (int i = 0; i < rq.size(); i++) begin
         if (rq[i].row == r) begin
            idx = i;
            break;
         end
      end
      checks++;
      if (a_vld_o[r]) begin
         if (idx < 0) begin
            errors++;
            $display("FAIL row%0d_unexpected cyc=%0d got data=%0d vld=1, required vld=0", r, cyc, got);
         end else begin
            if (rq[idx].due != cyc || rq[idx].d !== got) begin
               errors++;
               $display("FAIL row%0d_data cyc=%0d got %0d, required %0d at cyc %0d",
                        r, cyc, got, rq[idx].d, rq[idx].due);
            end
            rq.delete(idx);
         end
      end else begin
         if (got !== '0) begin
            errors++;
            $display("FAIL row%0d_bubble cyc=%0d got %0d with vld=0, required 0", r, cyc, got);
         end else if (idx >= 0 && rq[idx].due <= cyc) begin
            errors++;
            $display("FAIL row%0d_missing cyc=%0d got vld=0, required %0d due cyc %0d",
                     r, cyc, rq[idx].d, rq[idx].due);
            rq.delete(idx);
         end
      end
   endtask

   always @(negedge clk_i) begin
      logic exp_done;
      if (in_rst) begin
         checks++;
         if (a_out_o !== '0 || a_vld_o !== '0 || done_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs a_out=%h a_vld=%b done=%b ready=%b, required all 0",
                     a_out_o, a_vld_o, done_o, in_ready_o);
         end
      end else begin
         checks++;
         if (in_ready_o !== exp_ready) begin
            errors++;
            $display("FAIL in_ready cyc=%0d got %b, required %b", cyc, in_ready_o, exp_ready);
         end
         exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
         checks++;
         if (done_o !== exp_done) begin
            errors++;
            $display("FAIL done cyc=%0d got %b, required %b", cyc, done_o, exp_done);
         end
         if (exp_done) void'(done_q.pop_front());
         for (int r = 0; r < ROWS; r++) row_check(r);
`ifdef SKEW_BEAT_CNT_EN
         checks++;
         if (int'(beat_cnt_o) != m_bcnt) begin
            errors++;
            $display("FAIL beat_cnt cyc=%0d got %0d, required %0d", cyc, beat_cnt_o, m_bcnt);
         end
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Driver + reference model. Called at posedge+1; drives one cycle.
   // A beat accepted at edge E shows row r in cycle E+r; the tile's done
   // and the end of the no-ready window fall in cycle E+ROWS-1.
   // ------------------------------------------------------------------------
   task automatic step(input logic v, input logic [W-1:0] d, input logic l, output logic acc);
      logic dn;
      ent_t e;
      in_valid_i = v;
      in_data_i  = d;
      in_last_i  = l;
      exp_ready  = (cyc > busy_until);
      acc        = v && exp_ready;
      if (acc) begin
         for (int r = 0; r < ROWS; r++) begin
            e.row = r;
            e.d   = d[r*DATA_W +: DATA_W];
            e.due = cyc + 1 + r;
            rq.push_back(e);
         end
         if (l) begin
            busy_until = cyc + ROWS;
            done_q.push_back(cyc + ROWS);
         end
      end
      dn = (done_q.size() > 0) && (done_q[0] == cyc);
      @(posedge clk_i);
      #1;
      if (dn) m_bcnt = 0;
      else if (acc && m_bcnt < 65535) m_bcnt++;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, a);
   endtask

   task automatic pulse_reset();
      rst_ni     = 1'b0;
      in_rst     = 1'b1;
      in_valid_i = 1'b0;
      exp_ready  = 1'b0;
      rq.delete();
      done_q.delete();
      m_bcnt     = 0;
      #1;
      checks++;
      if (a_out_o !== '0 || a_vld_o !== '0 || done_o !== 1'b0 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_immediate a_out=%h a_vld=%b done=%b ready=%b, required all 0",
                  a_out_o, a_vld_o, done_o, in_ready_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni     = 1'b1;
      in_rst     = 1'b0;
      busy_until = cyc - 1;
      exp_ready  = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      int   nb, sent;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni     = 1'b1;
      in_rst     = 1'b0;
      busy_until = cyc - 1;
      exp_ready  = 1'b1;
      idle(2);

      // Single last beat {4,3,2,1}
      step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, a);
      idle(ROWS + 1);

      // Three back-to-back beats, last on the 7s
      step(1'b1, {4{8'd5}}, 1'b0, a);
      step(1'b1, {4{8'd6}}, 1'b0, a);
      step(1'b1, {4{8'd7}}, 1'b1, a);
      idle(ROWS + 1);

      // Bubble between two beats
      step(1'b1, {8'd14, 8'd13, 8'd12, 8'd11}, 1'b0, a);
      step(1'b0, '0, 1'b0, a);
      step(1'b1, {8'd24, 8'd23, 8'd22, 8'd21}, 1'b1, a);
      idle(ROWS + 1);

      // Most negative value on all rows
      step(1'b1, {4{8'h80}}, 1'b1, a);
      idle(ROWS + 1);

      // Reset in the second drain cycle, then a clean tile
      step(1'b1, {8'd44, 8'd43, 8'd42, 8'd41}, 1'b1, a);
      idle(1);
      pulse_reset();
      idle(1);
      step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, a);
      idle(ROWS + 1);

      // Random tiles; valid is also driven while the block is busy
      for (int t = 0; t < 150; t++) begin
         nb   = $urandom_range(1, 5);
         sent = 0;
         while (sent < nb) begin
            step(($urandom_range(0, 3) != 0), W'($urandom),
                 (sent == nb - 1) ? 1'b1 : 1'(($urandom_range(0, 1))), a);
            if (a) sent++;
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      for (int i = 0; i < 40 && (rq.size() > 0 || done_q.size() > 0); i++) idle(1);
      checks++;
      if (rq.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL leftover got %0d row elements and %0d done pulses outstanding, required 0",
                  rq.size(), done_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
